hwfifo_bank: RTL and testbench

- Memory-mapped bank of NCHAN independent receive FIFOs for byte/word streams from peripherals such as UART RX, keyboard and future serial devices.
- Sits on the CPU hardware-register bus and provides per-channel level, sticky overflow, programmable watermark and a masked interrupt output.
- Generalises the per-device inline FIFO-with-(-1)-on-empty read scheme to parametrised width, depth and channel count.

---
 rtl/hwfifo_bank.sv | 139 +++++++++++++
 tb/tb_hwfifo_bank.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hwfifo_bank.sv
// Bank of NCHAN independent receive FIFOs behind a word-addressed register bus.
// Each channel exposes DATA/LEVEL/STATUS/THRESH; global IRQ_PENDING/IRQ_ENABLE drive a masked irq.
module hwfifo_bank #(
  parameter int unsigned NCHAN      = 4,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     request,
  input  logic [15:0]              address,
  input  logic                     write,
  input  logic [3:0]               wstrb,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     valid,
  input  logic [NCHAN-1:0]         in_valid,
  input  logic [NCHAN*DATA_W-1:0]  in_data,
  output logic                     irq
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LW    = DEPTH_LOG2 + 1;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [LW-1:0]         lvl_t;

  logic             rd_req, wr_req, chan_sel, glb_pend, glb_en;
  logic [1:0]       reg_sel;
  logic [31:0]      lane_mask;
  logic [NCHAN-1:0] pending;
  logic [NCHAN-1:0] irq_en_q, irq_en_d;
  logic [31:0]      rd_chain [NCHAN+1];
  logic [31:0]      rdata_q;
  logic             valid_q, irq_q;
  logic             unused;

  assign rd_req    = request && !write;
  assign wr_req    = request && write;
  assign chan_sel  = (address[15:8] == 8'h00);
  assign reg_sel   = address[3:2];
  assign glb_pend  = (address[15:2] == 14'h0040);
  assign glb_en    = (address[15:2] == 14'h0041);
  assign lane_mask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  assign unused    = ^{address[1:0], wdata, lane_mask};

  // Read data is OR-combined along a chain; at most one source is non-zero.
  assign rd_chain[0] = !rd_req  ? '0 :
                       glb_pend ? 32'(pending) :
                       glb_en   ? 32'(irq_en_q) : '0;

  always_comb begin
    irq_en_d = irq_en_q;
    if (wr_req && glb_en && wstrb[0]) irq_en_d = wdata[NCHAN-1:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q  <= '0;
      valid_q  <= 1'b0;
      irq_q    <= 1'b0;
      irq_en_q <= '0;
    end else begin
      rdata_q  <= rd_chain[NCHAN];
      valid_q  <= request;
      irq_q    <= |(pending & irq_en_q);
      irq_en_q <= irq_en_d;
    end
  end

  assign rdata = rdata_q;
  assign valid = valid_q;
  assign irq   = irq_q;

  for (genvar c = 0; c < NCHAN; c++) begin : g_ch
    logic [DATA_W-1:0] mem_q [DEPTH];
    ptr_t        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    lvl_t        level_q, level_d, thresh_q, thresh_d;
    logic        ovf_q, ovf_d;
    logic        hit, full, empty, pop, push_ok;
    logic [31:0] rd_val;

    assign hit        = chan_sel && (address[7:4] == 4'(c));
    assign full       = (level_q == lvl_t'(DEPTH));
    assign empty      = (level_q == '0);
    assign pop        = rd_req && hit && (reg_sel == 2'd0) && !empty;
    assign push_ok    = in_valid[c] && !full;
    assign pending[c] = ovf_q || ((thresh_q != '0) && (level_q >= thresh_q));

    always_comb begin
      rd_val = '0;
      if (rd_req && hit) begin
        case (reg_sel)
          2'd0:    rd_val = empty ? '1 : 32'(mem_q[rd_ptr_q]);
          2'd1:    rd_val = 32'(level_q);
          2'd2:    rd_val = {28'd0, pending[c], ovf_q, full, !empty};
          default: rd_val = 32'(thresh_q);
        endcase
      end
    end

    assign rd_chain[c+1] = rd_chain[c] | rd_val;

    // Fullness is judged on the start-of-cycle level, so a same-cycle pop never rescues a push.
    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      thresh_d = thresh_q;
      ovf_d    = ovf_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + ptr_t'(1);
      level_d = level_q + lvl_t'(push_ok) - lvl_t'(pop);
      if (wr_req && hit && (reg_sel == 2'd2) && wstrb[0] && wdata[2]) ovf_d = 1'b0;
      if (in_valid[c] && full) ovf_d = 1'b1;
      if (wr_req && hit && (reg_sel == 2'd3))
        thresh_d = (thresh_q & ~lane_mask[LW-1:0]) | (wdata[LW-1:0] & lane_mask[LW-1:0]);
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
        thresh_q <= '0;
        ovf_q    <= 1'b0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
        thresh_q <= thresh_d;
        ovf_q    <= ovf_d;
      end
    end

    always_ff @(posedge clock) begin
      if (!reset && push_ok) mem_q[wr_ptr_q] <= in_data[c*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_hwfifo_bank.sv
// Directed plus randomized bench for hwfifo_bank, checked against a queue-based model.
module tb_hwfifo_bank;
  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int DL2   = 4;
  localparam int DEPTH = 16;

  logic              clock = 1'b0;
  logic              reset, request, write, valid, irq;
  logic [15:0]       address;
  logic [3:0]        wstrb;
  logic [31:0]       wdata, rdata;
  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;

  always #5 clock = ~clock;

  hwfifo_bank #(.NCHAN(NCH), .DATA_W(DW), .DEPTH_LOG2(DL2)) dut (
    .clock(clock), .reset(reset), .request(request), .address(address),
    .write(write), .wstrb(wstrb), .wdata(wdata), .rdata(rdata), .valid(valid),
    .in_valid(in_valid), .in_data(in_data), .irq(irq)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0]     mq [NCH][$];
  bit             m_ovf [NCH];
  int             m_th [NCH];
  logic [NCH-1:0] m_en;
  logic [31:0]    last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_pend(input int c);
    return m_ovf[c] || (m_th[c] != 0 && mq[c].size() >= m_th[c]);
  endfunction

  function automatic void m_clear();
    for (int c = 0; c < NCH; c++) begin
      mq[c].delete();
      m_ovf[c] = 1'b0;
      m_th[c]  = 0;
    end
    m_en = '0;
  endfunction

  // One bus/push cycle: drive, predict from the pre-cycle model state, update model, check.
  task automatic step(input bit rq, input bit wr, input logic [15:0] a, input logic [3:0] st,
                      input logic [31:0] wd, input logic [NCH-1:0] iv, input logic [31:0] id);
    int          ch, rg;
    bit          chan, ei;
    bit          full0 [NCH];
    logic [31:0] e;
    logic [7:0]  b;
    request = rq; write = wr; address = a; wstrb = st; wdata = wd;
    in_valid = iv; in_data = id;
    ei = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (m_en[c] && m_pend(c)) ei = 1'b1;
      full0[c] = (mq[c].size() == DEPTH);
    end
    ch   = int'(a[7:4]);
    rg   = int'(a[3:2]);
    chan = (a[15:8] == 8'h00) && (ch < NCH);
    e = '0;
    if (rq && !wr) begin
      if (chan) begin
        case (rg)
          0: e = (mq[ch].size() > 0) ? 32'(mq[ch].pop_front()) : 32'hFFFF_FFFF;
          1: e = 32'(mq[ch].size());
          2: e = {28'd0, m_pend(ch), m_ovf[ch], full0[ch], mq[ch].size() != 0};
          default: e = 32'(m_th[ch]);
        endcase
      end else if (a[15:2] == 14'h0040) begin
        for (int c = 0; c < NCH; c++) e[c] = m_pend(c);
      end else if (a[15:2] == 14'h0041) begin
        e = 32'(m_en);
      end
    end
    if (rq && wr) begin
      if (chan && rg == 2 && st[0] && wd[2]) m_ovf[ch] = 1'b0;
      if (chan && rg == 3 && st[0]) m_th[ch] = int'(wd[4:0]);
      if (a[15:2] == 14'h0041 && st[0]) m_en = wd[NCH-1:0];
    end
    for (int c = 0; c < NCH; c++) begin
      if (iv[c]) begin
        b = 8'(id >> (8 * c));
        if (full0[c]) m_ovf[c] = 1'b1;
        else mq[c].push_back(b);
      end
    end
    @(posedge clock);
    #1;
    check("valid", 32'(valid), 32'(rq));
    check("rdata", rdata, e);
    check("irq", 32'(irq), 32'(ei));
    last_rd = rdata;
  endtask

  task automatic do_reset(input bit rq);
    reset = 1'b1; request = rq; write = 1'b0; address = 16'h0000;
    wstrb = '0; wdata = '0; in_valid = '1; in_data = 32'h0102_0304;
    m_clear();
    @(posedge clock);
    #1;
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0; in_valid = '0; request = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    step(1'b1, 1'b0, a, 4'h0, 32'h0, '0, 32'h0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    step(1'b1, 1'b1, a, 4'hF, d, '0, 32'h0);
  endtask

  task automatic push(input logic [NCH-1:0] iv, input logic [31:0] id);
    step(1'b0, 1'b0, 16'h0, 4'h0, 32'h0, iv, id);
  endtask

  function automatic logic [15:0] rand_addr();
    int k, rg;
    k  = $urandom_range(0, 15);
    rg = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 3);
    if (k < 11) return 16'($urandom_range(0, 5) * 16 + rg * 4 + $urandom_range(0, 3));
    if (k < 14) return 16'(256 + $urandom_range(0, 2) * 4 + $urandom_range(0, 3));
    return 16'($urandom);
  endfunction

  initial begin
    logic [NCH-1:0] iv;
    int             pdiv;
    m_clear();
    do_reset(1'b0);

    rd(16'h000); check("empty_data", last_rd, 32'hFFFF_FFFF);
    rd(16'h004); check("empty_level", last_rd, 32'h0);
    rd(16'h008); check("empty_status", last_rd, 32'h0);

    push(4'b0010, 32'h0000_4100);
    push(4'b0010, 32'h0000_4200);
    rd(16'h010); check("ch1_first", last_rd, 32'h41);
    rd(16'h010); check("ch1_second", last_rd, 32'h42);
    rd(16'h014); check("ch1_level0", last_rd, 32'h0);
    rd(16'h010); check("ch1_empty", last_rd, 32'hFFFF_FFFF);

    for (int i = 0; i < DEPTH; i++) push(4'b0001, 32'(i));
    push(4'b0001, 32'hAA);
    rd(16'h008); check("ch0_status_ovf", last_rd, 32'hF);
    for (int i = 0; i < DEPTH; i++) begin
      rd(16'h000); check("ch0_drain", last_rd, 32'(i));
    end
    rd(16'h000); check("ch0_no_aa", last_rd, 32'hFFFF_FFFF);
    step(1'b1, 1'b1, 16'h008, 4'h1, 32'h4, '0, 32'h0);
    rd(16'h008); check("ch0_ovf_clr", last_rd, 32'h0);

    step(1'b1, 1'b1, 16'h02C, 4'h1, 32'h3, '0, 32'h0);
    step(1'b1, 1'b1, 16'h104, 4'h1, 32'h4, '0, 32'h0);
    push(4'b0100, 32'h0011_0000);
    push(4'b0100, 32'h0022_0000);
    push('0, 32'h0); check("irq_below_wm", 32'(irq), 32'd0);
    push(4'b0100, 32'h0033_0000);
    push('0, 32'h0); check("irq_at_wm", 32'(irq), 32'd1);
    rd(16'h100); check("irq_pending", last_rd, 32'h4);
    rd(16'h020);
    push('0, 32'h0); check("irq_after_pop", 32'(irq), 32'd0);

    for (int i = 0; i < DEPTH; i++) push(4'b1000, 32'(i + 100) << 24);
    step(1'b1, 1'b0, 16'h030, 4'h0, 32'h0, 4'b1000, 32'hEE00_0000);
    check("ch3_pop_full", last_rd, 32'd100);
    rd(16'h034); check("ch3_level", last_rd, 32'(DEPTH - 1));
    rd(16'h038); check("ch3_status", last_rd, 32'hD);
    step(1'b1, 1'b1, 16'h038, 4'h1, 32'h4, '0, 32'h0);
    for (int i = 0; i < DEPTH - 6; i++) rd(16'h030);
    rd(16'h034); check("ch3_level5", last_rd, 32'd5);
    step(1'b1, 1'b0, 16'h030, 4'h0, 32'h0, 4'b1000, 32'h7700_0000);
    rd(16'h034); check("ch3_pushpop", last_rd, 32'd5);

    for (int i = 0; i < 3; i++) push('1, 32'h5566_7788);
    do_reset(1'b1);
    for (int c = 0; c < NCH; c++) begin
      rd(16'(c * 16 + 4)); check("post_rst_level", last_rd, 32'h0);
    end
    push(4'b0001, 32'h0000_0099);
    push('0, 32'h0);
    rd(16'h000); check("post_rst_data", last_rd, 32'h99);

    for (int n = 0; n < 4000; n++) begin
      pdiv = ((n / 300) % 2 == 0) ? 3 : 40;
      for (int c = 0; c < NCH; c++) iv[c] = ($urandom_range(0, pdiv - 1) == 0);
      if ($urandom_range(0, 799) == 0) begin
        do_reset($urandom_range(0, 1) == 1);
      end else begin
        step($urandom_range(0, 9) < 7, $urandom_range(0, 4) == 0, rand_addr(),
             4'($urandom), $urandom, iv, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
